// File: rtl/rice_core_div_radix.sv
// Iterative radix-2^BITS_PER_CYCLE restoring divider for DIV/DIVU/REM/REMU.
// Operands are captured at accept; divide-by-zero and signed overflow finish
// in one cycle, everything else takes XLEN/BITS_PER_CYCLE CALC cycles.

package rice_core_div_pkg;
    typedef struct packed {
        logic div;
        logic divu;
        logic rem;
        logic remu;
    } rice_core_div_operation;
endpackage

module rice_core_div_radix
    import rice_core_div_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [XLEN-1:0]        i_rs1_value,
    input  logic [XLEN-1:0]        i_rs2_value,
    input  rice_core_div_operation i_div_operation,
    output logic                   o_result_valid,
    input  logic                   i_result_ready,
    output logic [XLEN-1:0]        o_result
);

    localparam int unsigned STEPS = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(STEPS + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            rem_op_q, rem_op_d;
    logic            neg_q, neg_d;
    logic            rs1_neg_q, rs1_neg_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            op_signed, op_rem, rs1_neg, rs2_neg;
    logic            div_by_zero, overflow;
    logic [XLEN-1:0] abs1, abs2;
    logic [XLEN:0]   r_w;
    logic [XLEN-1:0] q_w;
    logic [XLEN-1:0] q_fix, r_fix;

    assign o_ready        = (state_q == ST_IDLE);
    assign o_result_valid = (state_q == ST_DONE);
    assign o_result       = result_q;

    // Decode the incoming request: magnitudes, signs and early-out cases
    always_comb begin
        op_signed   = i_div_operation.div | i_div_operation.rem;
        op_rem      = i_div_operation.rem | i_div_operation.remu;
        rs1_neg     = op_signed & i_rs1_value[XLEN-1];
        rs2_neg     = op_signed & i_rs2_value[XLEN-1];
        abs1        = rs1_neg ? (-i_rs1_value) : i_rs1_value;
        abs2        = rs2_neg ? (-i_rs2_value) : i_rs2_value;
        div_by_zero = (i_rs2_value == '0);
        overflow    = op_signed && (i_rs1_value == INT_MIN) && (i_rs2_value == '1);
    end

    // BITS_PER_CYCLE chained shift/compare/subtract steps plus sign fixup
    always_comb begin
        r_w = {1'b0, rem_q};
        q_w = quot_q;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            r_w = {r_w[XLEN-1:0], q_w[XLEN-1]};
            q_w = {q_w[XLEN-2:0], 1'b0};
            if (r_w >= {1'b0, divisor_q}) begin
                r_w    = r_w - {1'b0, divisor_q};
                q_w[0] = 1'b1;
            end
        end
        q_fix = neg_q ? (-q_w) : q_w;
        r_fix = rs1_neg_q ? (-r_w[XLEN-1:0]) : r_w[XLEN-1:0];
    end

    // Next-state logic; flush overrides every other transition
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_op_d  = rem_op_q;
        neg_d     = neg_q;
        rs1_neg_d = rs1_neg_q;
        divisor_d = divisor_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        result_d  = result_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    rem_op_d  = op_rem;
                    neg_d     = rs1_neg ^ rs2_neg;
                    rs1_neg_d = rs1_neg;
                    divisor_d = abs2;
                    quot_d    = abs1;
                    rem_d     = '0;
                    if (div_by_zero) begin
                        result_d = op_rem ? i_rs1_value : '1;
                        cnt_d    = '0;
                        state_d  = ST_DONE;
                    end else if (overflow) begin
                        result_d = op_rem ? '0 : i_rs1_value;
                        cnt_d    = '0;
                        state_d  = ST_DONE;
                    end else begin
                        cnt_d   = CNT_W'(STEPS);
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                quot_d = q_w;
                rem_d  = r_w[XLEN-1:0];
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d = rem_op_q ? r_fix : q_fix;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (i_flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_op_q  <= 1'b0;
            neg_q     <= 1'b0;
            rs1_neg_q <= 1'b0;
            divisor_q <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_op_q  <= rem_op_d;
            neg_q     <= neg_d;
            rs1_neg_q <= rs1_neg_d;
            divisor_q <= divisor_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
        end
    end

endmodule

// File: tb/tb_rice_core_div_radix.sv
// Self-checking bench for rice_core_div_radix: directed vector table,
// hand-written handshake/flush/reset sequences and randomised ops against
// an arithmetic reference model.

module tb_rice_core_div_radix;
    import rice_core_div_pkg::*;

    localparam logic [3:0] OP_DIV  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b0100;
    localparam logic [3:0] OP_REM  = 4'b0010;
    localparam logic [3:0] OP_REMU = 4'b0001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush_s = 1'b0;
    logic valid_s = 1'b0;
    logic ready_o;
    logic [31:0] rs1_s = '0, rs2_s = '0;
    rice_core_div_operation op_s = '0;
    logic rvalid_o;
    logic rready_s = 1'b0;
    logic [31:0] result_o;

    // Auxiliary instances for the other radix settings
    logic av1 = 1'b0, av4 = 1'b0;
    logic [31:0] a_rs1 = '0, a_rs2 = '0;
    rice_core_div_operation a_op = '0;
    logic rdy1, rdy4, rv1, rv4;
    logic [31:0] res1, res4;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rice_core_div_radix #(.XLEN(32), .BITS_PER_CYCLE(2)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush_s), .i_valid(valid_s),
        .o_ready(ready_o), .i_rs1_value(rs1_s), .i_rs2_value(rs2_s),
        .i_div_operation(op_s), .o_result_valid(rvalid_o),
        .i_result_ready(rready_s), .o_result(result_o));

    rice_core_div_radix #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush_s), .i_valid(av1),
        .o_ready(rdy1), .i_rs1_value(a_rs1), .i_rs2_value(a_rs2),
        .i_div_operation(a_op), .o_result_valid(rv1),
        .i_result_ready(1'b1), .o_result(res1));

    rice_core_div_radix #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush_s), .i_valid(av4),
        .o_ready(rdy4), .i_rs1_value(a_rs2 == a_rs2 ? a_rs1 : a_rs1), .i_rs2_value(a_rs2),
        .i_div_operation(a_op), .o_result_valid(rv4),
        .i_result_ready(1'b1), .o_result(res4));

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: RISC-V M-extension semantics via 64-bit arithmetic
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            res = (op == OP_DIV || op == OP_DIVU) ? 32'hFFFF_FFFF : a;
        end else if (op == OP_DIV || op == OP_REM) begin
            q = sa / sb;
            r = sa % sb;
            res = (op == OP_DIV) ? q[31:0] : r[31:0];
        end else begin
            res = (op == OP_DIVU) ? (a / b) : (a % b);
        end
        return res;
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int bpc);
        bit sgn;
        sgn = (op == OP_DIV || op == OP_REM);
        if (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return 1 + 32 / bpc;
    endfunction

    // Issue one request on the main instance, optionally stall the consumer
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int bp, output logic [31:0] res, output int lat,
                         output bit held, output bit back_idle);
        int guard;
        guard = 0;
        while (!ready_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        valid_s = 1'b1;
        op_s    = op;
        rs1_s   = a;
        rs2_s   = b;
        @(negedge clk);
        valid_s = 1'b0;
        rs1_s   = $urandom;
        rs2_s   = $urandom;
        op_s    = 4'b0001 << $urandom_range(0, 3);
        lat = 1;
        while (!rvalid_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res  = result_o;
        held = 1'b1;
        repeat (bp) begin
            @(negedge clk);
            if (!rvalid_o || result_o !== res || ready_o) held = 1'b0;
        end
        rready_s = 1'b1;
        @(negedge clk);
        rready_s = 1'b0;
        back_idle = ready_o && !rvalid_o;
    endtask

    // Issue one request on an auxiliary instance (1 = radix-2, 4 = radix-16)
    task automatic aux_op(input int which, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res, output int lat);
        a_op  = op;
        a_rs1 = a;
        a_rs2 = b;
        if (which == 1) av1 = 1'b1; else av4 = 1'b1;
        @(negedge clk);
        av1 = 1'b0;
        av4 = 1'b0;
        lat = 1;
        while (!((which == 1) ? rv1 : rv4) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = (which == 1) ? res1 : res4;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd0;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] res;
        int lat;
        bit held, idle;
        int seen;

        tbl.push_back('{OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 17});
        tbl.push_back('{OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 17});
        tbl.push_back('{OP_DIVU, 32'd100,       32'd7,         32'd14,        17});
        tbl.push_back('{OP_REMU, 32'd100,       32'd7,         32'd2,         17});
        tbl.push_back('{OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1});
        tbl.push_back('{OP_REM,  32'd5,         32'd0,         32'd5,         1});
        tbl.push_back('{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        tbl.push_back('{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1});
        tbl.push_back('{OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 17});
        tbl.push_back('{OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         17});
        tbl.push_back('{OP_DIV,  32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'd4,         17});
        tbl.push_back('{OP_REM,  32'hFFFF_FFF8, 32'd3,         32'hFFFF_FFFE, 17});
        tbl.push_back('{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         17});
        tbl.push_back('{OP_REMU, 32'hFFFF_FFFF, 32'h10,        32'hF,         17});
        tbl.push_back('{OP_DIV,  32'h8000_0000, 32'd1,         32'h8000_0000, 17});
        tbl.push_back('{OP_REMU, 32'd3,         32'd5,         32'd3,         17});

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset_ready", ready_o, 1);
        chk("reset_rvalid", rvalid_o, 0);
        chk("reset_result", result_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        foreach (tbl[i]) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, res, lat, held, idle);
            chk($sformatf("vec%0d_result", i), res, tbl[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
        end

        // Other radix settings
        aux_op(1, OP_DIVU, 32'd100, 32'd7, res, lat);
        chk("bpc1_divu", res, 14);
        chk("bpc1_latency", lat, 33);
        aux_op(1, OP_REMU, 32'd100, 32'd7, res, lat);
        chk("bpc1_remu", res, 2);
        aux_op(4, OP_DIVU, 32'd100, 32'd7, res, lat);
        chk("bpc4_divu", res, 14);
        chk("bpc4_latency", lat, 9);
        aux_op(4, OP_REM, 32'hFFFF_FFF9, 32'd2, res, lat);
        chk("bpc4_rem", res, 32'hFFFF_FFFF);

        // Back-pressure: 10 stalled cycles in DONE
        do_op(OP_DIVU, 32'd100, 32'd7, 10, res, lat, held, idle);
        chk("bp_result", res, 14);
        chk("bp_held", held, 1);
        chk("bp_back_to_idle", idle, 1);

        // Flush at CALC cycle 5 drops the operation
        valid_s = 1'b1; op_s = OP_DIVU; rs1_s = 32'd1000; rs2_s = 32'd3;
        @(negedge clk);
        valid_s = 1'b0;
        repeat (4) @(negedge clk);
        flush_s = 1'b1;
        @(negedge clk);
        flush_s = 1'b0;
        chk("flush_calc_ready", ready_o, 1);
        seen = 0;
        repeat (25) begin
            if (rvalid_o) seen++;
            @(negedge clk);
        end
        chk("flush_calc_no_result", seen, 0);
        do_op(OP_DIVU, 32'd9, 32'd3, 0, res, lat, held, idle);
        chk("after_flush_result", res, 3);
        chk("after_flush_latency", lat, 17);

        // Flush in DONE drops the result
        valid_s = 1'b1; op_s = OP_DIVU; rs1_s = 32'd5; rs2_s = 32'd0;
        @(negedge clk);
        valid_s = 1'b0;
        chk("flush_done_pre_valid", rvalid_o, 1);
        flush_s = 1'b1;
        @(negedge clk);
        flush_s = 1'b0;
        chk("flush_done_valid", rvalid_o, 0);
        chk("flush_done_ready", ready_o, 1);

        // Flush together with a request: not accepted
        valid_s = 1'b1; flush_s = 1'b1; op_s = OP_DIVU; rs1_s = 32'd5; rs2_s = 32'd0;
        @(negedge clk);
        valid_s = 1'b0; flush_s = 1'b0;
        seen = 0;
        repeat (20) begin
            if (rvalid_o || !ready_o) seen++;
            @(negedge clk);
        end
        chk("flush_accept_rejected", seen, 0);

        // Asynchronous reset in the middle of CALC
        do_op(OP_DIVU, 32'd100, 32'd7, 0, res, lat, held, idle);
        valid_s = 1'b1; op_s = OP_DIV; rs1_s = 32'd77; rs2_s = 32'd5;
        @(negedge clk);
        valid_s = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", ready_o, 1);
        chk("async_rst_rvalid", rvalid_o, 0);
        chk("async_rst_result", result_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            if (rvalid_o) seen++;
            @(negedge clk);
        end
        chk("async_rst_no_result", seen, 0);

        // Randomised ops with random back-pressure
        for (int i = 0; i < 150; i++) begin
            logic [3:0] op;
            logic [31:0] a, b;
            int bp;
            op = 4'b0001 << $urandom_range(0, 3);
            a  = rnd_operand();
            b  = rnd_operand();
            if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 15);
            bp = $urandom_range(0, 3);
            do_op(op, a, b, bp, res, lat, held, idle);
            chk($sformatf("rand%0d_op%0h_%08h_%08h", i, op, a, b), res, model(op, a, b));
            chk($sformatf("rand%0d_latency", i), lat, model_lat(op, a, b, 2));
            chk($sformatf("rand%0d_handshake", i), {held, idle}, 2'b11);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog");
    end

endmodule
